// File: rtl/ssp_pkg.sv
// Shared SSP definitions: sequencer state encoding and default frame geometry.
package ssp_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FSS   = 2'd1;
  localparam logic [1:0] ST_SHIFT = 2'd2;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_CLK_HALF   = 1;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ssp_clk_gen.sv
// SSPCLKOUT generator: H phase then L phase, CLK_HALF PCLK cycles each,
// restarting from the H phase whenever the sequencer leaves IDLE.
module ssp_clk_gen
  import ssp_pkg::*;
#(
  parameter int CLK_HALF = DEF_CLK_HALF
) (
  input  logic PCLK,
  input  logic CLEAR,
  input  logic en,
  output logic sspclk,
  output logic phase_h_end,
  output logic phase_l_end
);

  localparam int             HCW   = cnt_width(CLK_HALF);
  localparam logic [HCW-1:0] HLAST = HCW'(CLK_HALF - 1);

  logic [HCW-1:0] hcnt_q, hcnt_d;
  logic           phase_l_q, phase_l_d;
  logic           half_done;

  // Half-period count, phase toggle and end-of-phase strobes.
  always_comb begin
    half_done   = en && (hcnt_q == HLAST);
    phase_h_end = half_done && !phase_l_q;
    phase_l_end = half_done && phase_l_q;
    sspclk      = en && !phase_l_q;
    hcnt_d      = hcnt_q;
    phase_l_d   = phase_l_q;
    if (!en) begin
      hcnt_d    = '0;
      phase_l_d = 1'b0;
    end else if (half_done) begin
      hcnt_d    = '0;
      phase_l_d = !phase_l_q;
    end else begin
      hcnt_d    = hcnt_q + 1'b1;
    end
  end

  // Counter and phase registers.
  always_ff @(posedge PCLK) begin
    if (CLEAR) begin
      hcnt_q    <= '0;
      phase_l_q <= 1'b0;
    end else begin
      hcnt_q    <= hcnt_d;
      phase_l_q <= phase_l_d;
    end
  end

endmodule

// File: rtl/ssp_frame_ctrl.sv
// Master-mode SSP frame sequencer: pops TX bytes, emits frame pulse and
// MSB-first serial data, assembles the received byte and pushes it.
module ssp_frame_ctrl
  import ssp_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int CLK_HALF   = DEF_CLK_HALF
) (
  input  logic                  PCLK,
  input  logic                  CLEAR,
  input  logic                  ENABLE,
  input  logic                  TX_EMPTY,
  input  logic [DATA_WIDTH-1:0] TX_DATA,
  output logic                  TX_POP,
  input  logic                  RX_FULL,
  output logic [DATA_WIDTH-1:0] RX_DATA,
  output logic                  RX_PUSH,
  input  logic                  SSPRXD,
  output logic                  SSPCLKOUT,
  output logic                  SSPFSSOUT,
  output logic                  SSPTXD,
  output logic                  SSPOE_B,
  output logic                  BUSY,
  output logic                  RX_OVR
);

  localparam int             BCW   = cnt_width(DATA_WIDTH);
  localparam logic [BCW-1:0] BLAST = BCW'(DATA_WIDTH - 1);

  logic [1:0]            state_q, state_d;
  logic [BCW-1:0]        bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0] tx_shift_q, tx_shift_d;
  logic [DATA_WIDTH-1:0] rx_shift_q, rx_shift_d;
  logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
  logic                  rx_push_q, rx_push_d;
  logic                  rx_ovr_q, rx_ovr_d;

  logic                  active;
  logic                  h_end, l_end;
  logic                  frame_end, last_sample, load;
  logic [DATA_WIDTH-1:0] rx_next;

  ssp_clk_gen #(
    .CLK_HALF (CLK_HALF)
  ) u_clk_gen (
    .PCLK        (PCLK),
    .CLEAR       (CLEAR),
    .en          (active),
    .sspclk      (SSPCLKOUT),
    .phase_h_end (h_end),
    .phase_l_end (l_end)
  );

  // Frame sequencing, shift datapath and receive completion.
  always_comb begin
    active      = (state_q != ST_IDLE);
    frame_end   = (state_q == ST_SHIFT) && l_end && (bit_cnt_q == '0);
    last_sample = (state_q == ST_SHIFT) && h_end && (bit_cnt_q == '0);
    // Popping is blocked during reset so an aborted cycle never consumes data.
    load        = !CLEAR && ENABLE && !TX_EMPTY &&
                  ((state_q == ST_IDLE) || frame_end);
    rx_next     = (rx_shift_q << 1) | DATA_WIDTH'(SSPRXD);

    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    tx_shift_d = tx_shift_q;
    rx_shift_d = rx_shift_q;

    case (state_q)
      ST_IDLE: begin
        if (load) state_d = ST_FSS;
      end
      ST_FSS: begin
        // No shift here: the frame-pulse bit period repeats the MSB.
        if (l_end) begin
          state_d   = ST_SHIFT;
          bit_cnt_d = BLAST;
        end
      end
      ST_SHIFT: begin
        if (h_end) rx_shift_d = rx_next;
        if (l_end) begin
          if (bit_cnt_q == '0) begin
            state_d = load ? ST_FSS : ST_IDLE;
          end else begin
            bit_cnt_d  = bit_cnt_q - 1'b1;
            tx_shift_d = tx_shift_q << 1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (load) tx_shift_d = TX_DATA;

    rx_push_d = last_sample && !RX_FULL;
    rx_ovr_d  = last_sample && RX_FULL;
    rx_data_d = rx_push_d ? rx_next : rx_data_q;
  end

  // Control and visible receive registers, cleared by CLEAR.
  always_ff @(posedge PCLK) begin
    if (CLEAR) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= '0;
      rx_push_q <= 1'b0;
      rx_ovr_q  <= 1'b0;
      rx_data_q <= '0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      rx_push_q <= rx_push_d;
      rx_ovr_q  <= rx_ovr_d;
      rx_data_q <= rx_data_d;
    end
  end

  // Shift registers; contents are reloaded or fully shifted before use.
  always_ff @(posedge PCLK) begin
    tx_shift_q <= tx_shift_d;
    rx_shift_q <= rx_shift_d;
  end

  assign TX_POP    = load;
  assign SSPFSSOUT = (state_q == ST_FSS);
  assign SSPTXD    = active && tx_shift_q[DATA_WIDTH-1];
  assign SSPOE_B   = !active;
  assign BUSY      = active;
  assign RX_PUSH   = rx_push_q;
  assign RX_OVR    = rx_ovr_q;
  assign RX_DATA   = rx_data_q;

endmodule

// File: tb/tb_ssp_frame_ctrl.sv
// Directed bench for ssp_frame_ctrl: CLK_HALF=1 instance with a FIFO model
// and per-cycle logs, plus a CLK_HALF=3 instance for timing scaling.
module tb_ssp_frame_ctrl;

  localparam int LOGN = 4096;

  logic       pclk = 1'b0;
  logic       clear, enable, tx_empty, rx_full, rxd_force, loop_en;
  logic [7:0] tx_data;
  logic       tx_pop, rx_push, rx_ovr, sclk, fss, txd, oe_b, busy, rxd;
  logic [7:0] rx_data;

  logic       clear3, en3, empty3;
  logic [7:0] data3, rx_data3;
  logic       pop3, push3, ovr3, sclk3, fss3, txd3, oe3, busy3;

  int  cyc = 0;
  int  n_chk = 0;
  int  n_pass = 0;
  logic [7:0] fifo[$];
  int  pop_cyc[$], push_cyc[$], ovr_cyc[$];
  logic [7:0] push_dat[$];
  logic txd_log[LOGN], fss_log[LOGN], clk_log[LOGN], busy_log[LOGN], oe_log[LOGN];
  logic pop_pend = 1'b0;

  assign rxd = loop_en ? txd : rxd_force;

  ssp_frame_ctrl #(.DATA_WIDTH(8), .CLK_HALF(1)) dut (
    .PCLK(pclk), .CLEAR(clear), .ENABLE(enable), .TX_EMPTY(tx_empty),
    .TX_DATA(tx_data), .TX_POP(tx_pop), .RX_FULL(rx_full), .RX_DATA(rx_data),
    .RX_PUSH(rx_push), .SSPRXD(rxd), .SSPCLKOUT(sclk), .SSPFSSOUT(fss),
    .SSPTXD(txd), .SSPOE_B(oe_b), .BUSY(busy), .RX_OVR(rx_ovr)
  );

  ssp_frame_ctrl #(.DATA_WIDTH(8), .CLK_HALF(3)) dut3 (
    .PCLK(pclk), .CLEAR(clear3), .ENABLE(en3), .TX_EMPTY(empty3),
    .TX_DATA(data3), .TX_POP(pop3), .RX_FULL(1'b0), .RX_DATA(rx_data3),
    .RX_PUSH(push3), .SSPRXD(txd3), .SSPCLKOUT(sclk3), .SSPFSSOUT(fss3),
    .SSPTXD(txd3), .SSPOE_B(oe3), .BUSY(busy3), .RX_OVR(ovr3)
  );

  initial forever #5 pclk = ~pclk;

  always @(posedge pclk) cyc <= cyc + 1;

  // Per-cycle trace of dut, sampled mid-cycle.
  always @(negedge pclk) begin
    if (cyc < LOGN) begin
      txd_log[cyc]  <= txd;
      fss_log[cyc]  <= fss;
      clk_log[cyc]  <= sclk;
      busy_log[cyc] <= busy;
      oe_log[cyc]   <= oe_b;
    end
    if (tx_pop) pop_cyc.push_back(cyc);
    if (rx_push) begin
      push_cyc.push_back(cyc);
      push_dat.push_back(rx_data);
    end
    if (rx_ovr) ovr_cyc.push_back(cyc);
    pop_pend <= tx_pop;
  end

  task automatic fifo_refresh();
    tx_empty = (fifo.size() == 0);
    tx_data  = tx_empty ? 8'h00 : fifo[0];
  endtask

  // First-word-fall-through FIFO model feeding dut.
  always @(posedge pclk) begin
    #1;
    if (pop_pend && fifo.size() > 0) void'(fifo.pop_front());
    fifo_refresh();
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge pclk);
    #2;
  endtask

  task automatic clear_logs();
    pop_cyc.delete();
    push_cyc.delete();
    push_dat.delete();
    ovr_cyc.delete();
  endtask

  task automatic fifo_load(input logic [7:0] b);
    fifo.push_back(b);
    fifo_refresh();
  endtask

  int c0, p0, bad, e1;
  logic [7:0] bh, bl;
  int r1, r2, bcnt, pc3;
  logic [7:0] pd3;
  logic prev;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    clear = 1'b1; clear3 = 1'b1; enable = 1'b0; en3 = 1'b0; empty3 = 1'b1;
    data3 = 8'h00; rx_full = 1'b0; rxd_force = 1'b0; loop_en = 1'b1;
    fifo_refresh();

    // Reset then idle.
    tick(); tick();
    @(negedge pclk);
    chk("rst_outs", {tx_pop, rx_push, rx_ovr, busy, sclk, fss, txd, oe_b}, 8'b0000_0001);
    chk("rst_rx_data", rx_data, 8'h00);
    @(posedge pclk); #2;
    clear = 1'b0; clear3 = 1'b0;
    bad = 0;
    repeat (50) begin
      @(negedge pclk);
      if (tx_pop || rx_push || rx_ovr || busy || sclk || fss || txd || !oe_b) bad++;
    end
    chk("idle_quiet", bad, 0);

    // Single byte loopback A5.
    enable = 1'b1;
    tick(); c0 = cyc; clear_logs(); fifo_load(8'hA5);
    repeat (25) tick();
    chk("a5_pop_count", pop_cyc.size(), 1);
    p0 = (pop_cyc.size() > 0) ? pop_cyc[0] : c0;
    chk("a5_pop_cycle", p0, c0);
    chk("a5_fss_window", {fss_log[p0], fss_log[p0+1], fss_log[p0+2], fss_log[p0+3]}, 4'b0110);
    chk("a5_clk_start", {clk_log[p0], clk_log[p0+1], clk_log[p0+2], clk_log[p0+3]}, 4'b0101);
    bh = 8'h00; bl = 8'h00;
    for (int k = 0; k < 8; k++) begin
      bh = {bh[6:0], txd_log[p0+3+2*k]};
      bl = {bl[6:0], txd_log[p0+4+2*k]};
    end
    chk("a5_txd_h", bh, 8'hA5);
    chk("a5_txd_l", bl, 8'hA5);
    chk("a5_push_count", push_cyc.size(), 1);
    chk("a5_push_cycle", (push_cyc.size() > 0) ? push_cyc[0] - p0 : -1, 18);
    chk("a5_push_data", (push_dat.size() > 0) ? push_dat[0] : 8'hxx, 8'hA5);
    chk("a5_busy_end", {busy_log[p0+18], busy_log[p0+19]}, 2'b10);
    chk("a5_oe_b", {oe_log[p0+1], oe_log[p0+18], oe_log[p0+19]}, 3'b001);
    chk("a5_ovr_none", ovr_cyc.size(), 0);

    // Back-to-back 3C, C3.
    tick(); c0 = cyc; clear_logs(); fifo_load(8'h3C); fifo_load(8'hC3);
    repeat (45) tick();
    chk("b2b_pop_count", pop_cyc.size(), 2);
    p0 = (pop_cyc.size() > 0) ? pop_cyc[0] : c0;
    chk("b2b_pop_gap", (pop_cyc.size() > 1) ? pop_cyc[1] - p0 : -1, 18);
    e1 = 0;
    for (int i = 0; i < 36; i++) if (clk_log[p0+1+i] !== ((i % 2) == 0)) e1++;
    chk("b2b_clk_continuous", e1, 0);
    chk("b2b_push_count", push_cyc.size(), 2);
    chk("b2b_push0", (push_dat.size() > 0) ? push_dat[0] : 8'hxx, 8'h3C);
    chk("b2b_push1", (push_dat.size() > 1) ? push_dat[1] : 8'hxx, 8'hC3);
    chk("b2b_push1_cycle", (push_cyc.size() > 1) ? push_cyc[1] - p0 : -1, 36);
    chk("b2b_idle_after", busy_log[p0+37], 1'b0);

    // Overrun with RX FIFO full.
    loop_en = 1'b0; rxd_force = 1'b1; rx_full = 1'b1;
    tick(); c0 = cyc; clear_logs(); fifo_load(8'h55);
    repeat (25) tick();
    p0 = (pop_cyc.size() > 0) ? pop_cyc[0] : c0;
    chk("ovr_push_none", push_cyc.size(), 0);
    chk("ovr_count", ovr_cyc.size(), 1);
    chk("ovr_cycle", (ovr_cyc.size() > 0) ? ovr_cyc[0] - p0 : -1, 18);
    chk("ovr_rx_data_held", rx_data, 8'hC3);
    rx_full = 1'b0; loop_en = 1'b1; rxd_force = 1'b0;

    // ENABLE dropped during bit 3.
    tick(); c0 = cyc; clear_logs(); fifo_load(8'h81); fifo_load(8'h7E);
    repeat (9) tick();
    enable = 1'b0;
    repeat (30) tick();
    p0 = (pop_cyc.size() > 0) ? pop_cyc[0] : c0;
    chk("en_pop_count", pop_cyc.size(), 1);
    chk("en_push_data", (push_dat.size() > 0) ? push_dat[0] : 8'hxx, 8'h81);
    chk("en_push_cycle", (push_cyc.size() > 0) ? push_cyc[0] - p0 : -1, 18);
    chk("en_busy_end", {busy_log[p0+18], busy_log[p0+19]}, 2'b10);
    chk("en_fifo_left", fifo.size(), 1);
    fifo.delete(); fifo_refresh();

    // CLEAR during bit 4.
    enable = 1'b1;
    tick(); c0 = cyc; clear_logs(); fifo_load(8'hF0);
    repeat (11) tick();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    repeat (25) tick();
    p0 = (pop_cyc.size() > 0) ? pop_cyc[0] : c0;
    chk("clr_pop_count", pop_cyc.size(), 1);
    chk("clr_abort", {busy_log[p0+11], busy_log[p0+12], oe_log[p0+12], clk_log[p0+12]}, 4'b1010);
    chk("clr_no_push", push_cyc.size() + ovr_cyc.size(), 0);
    chk("clr_rx_data", rx_data, 8'h00);

    // CLK_HALF=3 single byte.
    en3 = 1'b1;
    tick(); c0 = cyc; empty3 = 1'b0; data3 = 8'h96;
    @(negedge pclk);
    chk("h3_pop", pop3, 1'b1);
    @(posedge pclk); #1;
    empty3 = 1'b1;
    r1 = -1; r2 = -1; bcnt = 0; pc3 = -1; pd3 = 8'h00; prev = 1'b0;
    repeat (70) begin
      @(negedge pclk);
      if (busy3) bcnt++;
      if (sclk3 && !prev) begin
        if (r1 < 0) r1 = cyc;
        else if (r2 < 0) r2 = cyc;
      end
      prev = sclk3;
      if (push3) begin
        pc3 = cyc;
        pd3 = rx_data3;
      end
    end
    chk("h3_clk_period", r2 - r1, 6);
    chk("h3_first_rise", r1 - c0, 1);
    chk("h3_busy_cycles", bcnt, 54);
    chk("h3_push_cycle", pc3 - c0, 52);
    chk("h3_push_data", pd3, 8'h96);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/ssp_frame_ctrl.md
Name: ssp_frame_ctrl

Overview:
Master-mode transmit/receive frame sequencer for the SSP.
- Sits between tx_fifo, rx_fifo and the serial pins.
- Pops bytes from the TX FIFO, generates SSPCLKOUT (PCLK/(2*CLK_HALF)) and a one-bit-period SSPFSSOUT frame pulse, and shifts each byte out MSB-first.
- Assembles the simultaneously received byte and pushes it into the RX FIFO.
- Runs back-to-back frames while TX data remains and ENABLE is high.

Parameters:
DATA_WIDTH, 8, bits per frame.
CLK_HALF, 1, PCLK cycles per SSPCLKOUT half-period (>=1).

Ports:
PCLK  in  1  system clock.
CLEAR  in  1  synchronous active-high reset.
ENABLE  in  1  transfer enable from control register.
TX_EMPTY  in  1  TX FIFO empty. The FIFO is first-word-fall-through: TX_DATA is valid whenever !TX_EMPTY.
TX_DATA  in  DATA_WIDTH  TX FIFO head word.
TX_POP  out  1  one-cycle pop strobe to TX FIFO.
RX_FULL  in  1  RX FIFO full.
RX_DATA  out  DATA_WIDTH  received byte, valid with RX_PUSH.
RX_PUSH  out  1  one-cycle push strobe to RX FIFO.
SSPRXD  in  1  serial receive data.
SSPCLKOUT  out  1  serial clock out.
SSPFSSOUT  out  1  frame sync out.
SSPTXD  out  1  serial transmit data.
SSPOE_B  out  1  active-low pad output enable.
BUSY  out  1  high while a frame is in progress.
RX_OVR  out  1  one-cycle pulse when a received byte is dropped.

Behaviour:
- Reset (CLEAR=1 at a PCLK edge):
  - state=IDLE.
  - SSPCLKOUT=0, SSPFSSOUT=0, SSPTXD=0, SSPOE_B=1.
  - TX_POP=0, RX_PUSH=0, RX_OVR=0, BUSY=0, RX_DATA=0.
  - Applies mid-frame too: the frame aborts, no push and no pop occur, and any partial byte is discarded.
- States: IDLE, FSS, SHIFT.
- Bit period = 2 phases of CLK_HALF PCLK cycles each: phase H (SSPCLKOUT=1), then phase L (SSPCLKOUT=0).
- IDLE:
  - TX_POP = ENABLE & !TX_EMPTY (combinational).
  - On that edge, latch TX_DATA into the TX shift register and go to FSS.
  - SSPCLKOUT stays 0.
- FSS:
  - One bit period with SSPFSSOUT=1.
  - SSPTXD = shift MSB, SSPOE_B=0, BUSY=1.
  - Then go to SHIFT with bit count = DATA_WIDTH-1.
- SHIFT:
  - DATA_WIDTH bit periods, SSPFSSOUT=0, SSPOE_B=0.
  - SSPTXD is the TX shift MSB and changes only at the H-phase start (SSPCLKOUT rising).
  - SSPRXD is sampled into the RX shift LSB at the last PCLK edge of phase H (SSPCLKOUT falling).
  - The TX shift register shifts left at the end of phase L.
- End of frame (last PCLK cycle of the last L phase):
  - If ENABLE & !TX_EMPTY: TX_POP=1 that cycle, latch TX_DATA, go to FSS. Back-to-back frames follow with no idle gap.
  - Else go to IDLE. SSPOE_B=1 and SSPTXD=0 from the next cycle.
- Receive completion, registered one cycle after the last sample edge:
  - RX_FULL=0: RX_PUSH=1 for one cycle and RX_DATA = assembled byte. RX_DATA holds until the next push.
  - RX_FULL=1: no push; RX_OVR=1 for one cycle; byte dropped.
  - This push/overrun cycle may coincide with the next frame's TX_POP or FSS.
- ENABLE deasserted mid-frame: the current frame completes (including its push); then IDLE.
- BUSY = (state != IDLE).
- With CLK_HALF=1, a single byte takes 18 PCLK cycles from the cycle after TX_POP to the return to IDLE, and RX_PUSH occurs at cycle 18 relative to TX_POP at cycle 0.
- Counters:
  - Half-period counter: ceil(log2(CLK_HALF)) bits, minimum 1.
  - Bit counter: ceil(log2(DATA_WIDTH)) bits.
  - Both reload from 0 and must not wrap inside a frame.

Decomposition:
- Shared package ssp_pkg: state encoding (IDLE/FSS/SHIFT) and default DATA_WIDTH/CLK_HALF constants, shared with the future slave-side sequencer.
- One natural sub-module: ssp_clk_gen. It holds the half-period counter and produces SSPCLKOUT plus single-cycle phase_h_end and phase_l_end strobes, enabled by !IDLE.
- Shift registers and the FSM stay in ssp_frame_ctrl.

Test Plan:
- Reset then idle: CLEAR=1 for 2 cycles, TX_EMPTY=1 -> all outputs at reset values, SSPOE_B=1, no strobes for 50 cycles.
- Single byte loopback (SSPRXD=SSPTXD, CLK_HALF=1): TX_DATA=8'hA5, TX_EMPTY falls at cycle 0.
  - TX_POP at cycle 0.
  - SSPFSSOUT=1 cycles 1-2.
  - SSPTXD bits 1,0,1,0,0,1,0,1.
  - RX_PUSH with RX_DATA=8'hA5 at cycle 18.
  - BUSY low from cycle 19.
- Back-to-back: FIFO holds 8'h3C, 8'hC3 -> second TX_POP exactly 18 cycles after the first, no gap in SSPCLKOUT, two pushes 3C then C3.
- Overrun: RX_FULL=1 during the frame, SSPRXD=1 -> no RX_PUSH, RX_OVR pulses once, and RX_DATA keeps its previous value.
- Mid-frame events:
  - ENABLE dropped at bit 3 -> frame completes and no further pop.
  - CLEAR at bit 4 -> IDLE next cycle, SSPOE_B=1, no RX_PUSH.
- CLK_HALF=3: SSPCLKOUT period = 6 PCLK, and a single-byte frame lasts 54 cycles after TX_POP.
